// File: rtl/pool_pkg.sv
// Shared definitions for the pooling window sequencer: sample width,
// sequencer state encoding and a signed max helper.
package pool_pkg;

  // Default sample width: 9 integer bits + 4 fractional bits.
  localparam int DATA_W = 13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Signed two's-complement maximum of two samples at the default width.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational signed two-input maximum. Ties return a, which is
// numerically identical to b, so the choice is irrelevant downstream.
module pool_max2
  import pool_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_max
);

  // Compare as signed so negative samples never beat positive ones.
  assign o_max = ($signed(i_a) >= $signed(i_b)) ? i_a : i_b;

endmodule

// File: rtl/pool_window_sequencer.sv
// 2x2 / stride-2 max-pool sequencer. Takes one {bottom,top} column per
// handshake from the pool line buffers, pairs even/odd columns and emits
// one pooled pixel per pair through a single output register. Counts
// columns and row pairs per frame and pulses o_intr when the last pooled
// pixel of the frame has been taken by the next layer.
module pool_window_sequencer
  import pool_pkg::*;
#(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int IMG_WIDTH        = 512,
  parameter int ROW_PAIRS        = 3,
  localparam int DW              = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic            o_busy,
  input  logic [2*DW-1:0] i_col_data,
  input  logic            i_col_valid,
  output logic            o_col_ready,
  output logic [DW-1:0]   o_pool_data,
  output logic            o_pool_valid,
  input  logic            i_pool_ready,
  output logic            o_intr
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(ROW_PAIRS) + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_PAIRS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [DW-1:0]    r_hold;
  logic [DW-1:0]    r_pool_data;
  logic             r_pool_valid;

  logic [DW-1:0]    w_top;
  logic [DW-1:0]    w_bot;
  logic [DW-1:0]    w_col_max;
  logic [DW-1:0]    w_hold_top_max;
  logic [DW-1:0]    w_pair_max;
  logic             w_stall;
  logic             w_col_ready;
  logic             w_col_fire;
  logic             w_odd_col;
  logic             w_last_col;

  assign w_top = i_col_data[DW-1:0];
  assign w_bot = i_col_data[2*DW-1:DW];

  // Even column reduces to max(top,bottom) for the hold register.
  pool_max2 #(.W(DW)) u_max_col (
    .i_a   (w_top),
    .i_b   (w_bot),
    .o_max (w_col_max)
  );

  // Odd column: max over held value, top and bottom, as a two-stage chain.
  pool_max2 #(.W(DW)) u_max_hold_top (
    .i_a   (r_hold),
    .i_b   (w_top),
    .o_max (w_hold_top_max)
  );

  pool_max2 #(.W(DW)) u_max_pair (
    .i_a   (w_hold_top_max),
    .i_b   (w_bot),
    .o_max (w_pair_max)
  );

  // A pending pixel that downstream refuses blocks all column intake,
  // even on even columns, which keeps the single output register rule simple.
  assign w_stall     = r_pool_valid & ~i_pool_ready;
  assign w_col_ready = (r_state == S_RUN) & ~w_stall;
  assign w_col_fire  = i_col_valid & w_col_ready;
  assign w_odd_col   = r_col[0];
  assign w_last_col  = (r_col == COL_LAST) & (r_row == ROW_LAST);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: one frame per start, drain the output register, then a one-cycle DONE.
  // NOTE: the default assignment at the top keeps this block free of latches
  // when no transition branch is taken.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_RUN;
      S_RUN:   if (w_col_fire && w_last_col) w_next_state = S_DRAIN;
      S_DRAIN: if (!r_pool_valid || i_pool_ready) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Column / row-pair counters: cleared on start, advanced per accepted column.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_col_fire) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Hold register captures the even column's max until its odd partner arrives.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hold <= '0;
    end else if (w_col_fire && !w_odd_col) begin
      r_hold <= w_col_max;
    end
  end

  // Output register: load on odd column, otherwise release when downstream takes it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pool_data  <= '0;
      r_pool_valid <= 1'b0;
    end else if (w_col_fire && w_odd_col) begin
      r_pool_data  <= w_pair_max;
      r_pool_valid <= 1'b1;
    end else if (i_pool_ready) begin
      r_pool_valid <= 1'b0;
    end
  end

  assign o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_col_ready  = w_col_ready;
  assign o_pool_data  = r_pool_data;
  assign o_pool_valid = r_pool_valid;
  assign o_intr       = (r_state == S_DONE);

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Self-checking bench for pool_window_sequencer. Two instances share the
// column/ready inputs: a full-size 512x3 one and a 4x1 one for short
// directed frames. Only the selected instance is started, so the other
// sits idle with its ready low. Expected pixels come from a plain
// max-of-four model over the generated column list.
module tb_pool_window_sequencer;

  localparam int DW      = 13;
  localparam int BIG_W   = 512;
  localparam int BIG_R   = 3;
  localparam int SMALL_W = 4;
  localparam int SMALL_R = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            start;
  logic            sel_small;
  logic [2*DW-1:0] col_data;
  logic            col_valid;
  logic            pool_ready;

  logic            b_start, b_busy, b_col_ready, b_pool_valid, b_intr;
  logic [DW-1:0]   b_pool_data;
  logic            s_start, s_busy, s_col_ready, s_pool_valid, s_intr;
  logic [DW-1:0]   s_pool_data;

  logic            obs_busy, obs_col_ready, obs_pool_valid, obs_intr;
  logic [DW-1:0]   obs_pool_data;

  assign b_start = start & ~sel_small;
  assign s_start = start & sel_small;

  assign obs_busy       = sel_small ? s_busy       : b_busy;
  assign obs_col_ready  = sel_small ? s_col_ready  : b_col_ready;
  assign obs_pool_valid = sel_small ? s_pool_valid : b_pool_valid;
  assign obs_intr       = sel_small ? s_intr       : b_intr;
  assign obs_pool_data  = sel_small ? s_pool_data  : b_pool_data;

  pool_window_sequencer #(
    .INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(BIG_W), .ROW_PAIRS(BIG_R)
  ) u_big (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (b_start),
    .o_busy       (b_busy),
    .i_col_data   (col_data),
    .i_col_valid  (col_valid),
    .o_col_ready  (b_col_ready),
    .o_pool_data  (b_pool_data),
    .o_pool_valid (b_pool_valid),
    .i_pool_ready (pool_ready),
    .o_intr       (b_intr)
  );

  pool_window_sequencer #(
    .INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(SMALL_W), .ROW_PAIRS(SMALL_R)
  ) u_small (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (s_start),
    .o_busy       (s_busy),
    .i_col_data   (col_data),
    .i_col_valid  (col_valid),
    .o_col_ready  (s_col_ready),
    .o_pool_data  (s_pool_data),
    .o_pool_valid (s_pool_valid),
    .i_pool_ready (pool_ready),
    .o_intr       (s_intr)
  );

  int checks   = 0;
  int failures = 0;
  int stall_seen;
  int intr_count;

  logic signed [DW-1:0] col_top[$];
  logic signed [DW-1:0] col_bot[$];
  logic signed [DW-1:0] exp_q[$];
  logic signed [DW-1:0] got_q[$];

  function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b,
                                                input logic signed [DW-1:0] c,
                                                input logic signed [DW-1:0] d);
    logic signed [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Reference: each adjacent column pair of the frame collapses to the max of its four samples.
  task automatic build_expected();
    exp_q.delete();
    for (int k = 0; k < col_top.size() / 2; k++)
      exp_q.push_back(max4(col_top[2*k], col_bot[2*k], col_top[2*k+1], col_bot[2*k+1]));
  endtask

  task automatic fill_random(input int n);
    logic signed [DW-1:0] t, b;
    col_top.delete();
    col_bot.delete();
    for (int i = 0; i < n; i++) begin
      t = DW'($urandom);
      b = DW'($urandom);
      col_top.push_back(t);
      col_bot.push_back(b);
    end
  endtask

  task automatic push_col(input int top, input int bot);
    logic signed [DW-1:0] t, b;
    t = DW'(top);
    b = DW'(bot);
    col_top.push_back(t);
    col_bot.push_back(b);
  endtask

  // Runs one frame on the selected instance: start pulse, then per-cycle
  // stimulus on the falling edge with outputs sampled 1 time unit later.
  // Returns at the falling edge where o_intr is seen (or on budget expiry).
  task automatic drive_frame(input int n, input bit gaps, input bit spam,
                             input int stall_from, input int stall_len, input int budget);
    int idx, cyc;
    bit done, prev_stall;
    logic [DW-1:0] prev_data;
    build_expected();
    got_q.delete();
    intr_count = 0;
    stall_seen = 0;
    idx = 0; cyc = 0; done = 0; prev_stall = 0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; col_valid = 1'b0; pool_ready = 1'b1;
    while (!done && cyc < budget) begin
      @(negedge clk);
      start = spam && obs_busy && ($urandom_range(0, 2) == 0);
      col_valid = (idx < n) && (!gaps || $urandom_range(0, 3) != 0);
      col_data  = (idx < n) ? {col_bot[idx], col_top[idx]} : '0;
      pool_ready = !(cyc >= stall_from && cyc < stall_from + stall_len) &&
                   (!gaps || $urandom_range(0, 3) != 0);
      #1;
      if (cyc == 0) begin
        checks++;
        if (obs_busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_after_start: got %b expected 1", obs_busy);
        end
      end
      if (prev_stall) begin
        checks++;
        if (obs_pool_valid !== 1'b1 || obs_pool_data !== prev_data) begin
          failures++;
          $display("FAIL held_output: got valid=%b data=%0d expected valid=1 data=%0d",
                   obs_pool_valid, $signed(obs_pool_data), $signed(prev_data));
        end
      end
      if (obs_pool_valid && !pool_ready) begin
        stall_seen++;
        checks++;
        if (obs_col_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_col_ready: got %b expected 0 (cycle %0d)", obs_col_ready, cyc);
        end
      end
      prev_stall = obs_pool_valid && !pool_ready;
      prev_data  = obs_pool_data;
      if (obs_pool_valid && pool_ready) got_q.push_back(obs_pool_data);
      if (col_valid && obs_col_ready) idx++;
      if (obs_intr === 1'b1) begin
        intr_count++;
        done = 1'b1;
        checks++;
        if (got_q.size() != exp_q.size() || idx != n) begin
          failures++;
          $display("FAIL intr_timing: got %0d pixels/%0d cols at intr, expected %0d/%0d",
                   got_q.size(), idx, exp_q.size(), n);
        end
      end
      cyc++;
    end
    start = 1'b0; col_valid = 1'b0; pool_ready = 1'b1;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL frame_timeout: got no intr within %0d cycles, expected one", budget);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL pixel_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL pixel[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag, input logic busy, input logic cr,
                                input logic pv, input logic [DW-1:0] pd, input logic intr);
    checks++;
    if ({busy, cr, pv, intr} !== 4'b0 || pd !== '0) begin
      failures++;
      $display("FAIL %s: got busy=%b ready=%b valid=%b data=%0d intr=%b expected all 0",
               tag, busy, cr, pv, pd, intr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_big", b_busy, b_col_ready, b_pool_valid, b_pool_data, b_intr);
    check_all_zero("reset_small", s_busy, s_col_ready, s_pool_valid, s_pool_data, s_intr);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    sel_small = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      col_data   = {DW'($urandom), DW'($urandom)};
      col_valid  = 1'b1;
      pool_ready = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_run", b_busy, b_col_ready, b_pool_valid, b_pool_data, b_intr);
    @(negedge clk);
    col_valid = 1'b0;
    rst_n = 1'b1;
    fill_random(BIG_W * BIG_R);
    drive_frame(BIG_W * BIG_R, 1'b0, 1'b0, 1 << 30, 0, 5000);
  endtask

  task automatic test_directed_small();
    sel_small = 1'b1;
    col_top.delete();
    col_bot.delete();
    push_col(3, -2);
    push_col(7, 1);
    push_col(-5, -6);
    push_col(-4, -9);
    drive_frame(SMALL_W * SMALL_R, 1'b0, 1'b0, 1 << 30, 0, 200);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 13'sd7 || got_q[1] !== -13'sd4) begin
      failures++;
      $display("FAIL directed_pair: got n=%0d first=%0d second=%0d expected n=2 7 -4",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 13'sd0,
               (got_q.size() > 1) ? got_q[1] : 13'sd0);
    end
    checks++;
    if (intr_count != 1) begin
      failures++;
      $display("FAIL directed_intr: got %0d pulses expected 1", intr_count);
    end
  endtask

  task automatic test_negative_window();
    sel_small = 1'b1;
    col_top.delete();
    col_bot.delete();
    push_col(-1, -8);
    push_col(-3, -2);
    push_col(5, 0);
    push_col(2, 4);
    drive_frame(SMALL_W * SMALL_R, 1'b0, 1'b0, 1 << 30, 0, 200);
    checks++;
    if (got_q.size() < 1 || got_q[0] !== -13'sd1) begin
      failures++;
      $display("FAIL negative_max: got %0d expected -1",
               (got_q.size() > 0) ? got_q[0] : 13'sd0);
    end
  endtask

  task automatic test_backpressure();
    sel_small = 1'b1;
    fill_random(SMALL_W * SMALL_R);
    drive_frame(SMALL_W * SMALL_R, 1'b0, 1'b0, 2, 10, 200);
    checks++;
    if (stall_seen < 10) begin
      failures++;
      $display("FAIL backpressure_cycles: got %0d stalled cycles expected >= 10", stall_seen);
    end
  endtask

  task automatic test_full_frame();
    sel_small = 1'b0;
    fill_random(BIG_W * BIG_R);
    drive_frame(BIG_W * BIG_R, 1'b1, 1'b0, 1 << 30, 0, 20000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs_intr !== 1'b0 || obs_busy !== 1'b0) begin
        failures++;
        $display("FAIL after_frame: got intr=%b busy=%b expected 0 0", obs_intr, obs_busy);
      end
    end
  endtask

  // Starts spammed during RUN/DRAIN must not restart the frame; each next
  // frame is started in the IDLE cycle right after DONE.
  task automatic test_start_ignored();
    sel_small = 1'b1;
    for (int f = 0; f < 4; f++) begin
      fill_random(SMALL_W * SMALL_R);
      drive_frame(SMALL_W * SMALL_R, 1'b1, 1'b1, 1 << 30, 0, 400);
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_frames: got busy=%b expected 0", obs_busy);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    sel_small  = 1'b0;
    col_data   = '0;
    col_valid  = 1'b0;
    pool_ready = 1'b1;
    test_reset();
    test_reset_mid_run();
    test_directed_small();
    test_negative_window();
    test_backpressure();
    test_full_frame();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
